// File: rtl/wb_sample_fifo_pkg.sv
// Shared register map, bit positions and packing helpers for the Wishbone sample FIFO slave.
package wb_sample_fifo_pkg;

    // Register offsets as decoded from wb_adr_i[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_TXDATA = 2'd2;
    localparam logic [1:0] REG_ID     = 2'd3;

    // CTRL fields
    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_FLUSH_BIT = 1;
    localparam int unsigned CTRL_WM_LSB    = 8;

    // STATUS fields
    localparam int unsigned LEVEL_W        = 9;
    localparam int unsigned STAT_EMPTY_BIT = 9;
    localparam int unsigned STAT_FULL_BIT  = 10;
    localparam int unsigned STAT_OVF_BIT   = 16;

    localparam logic [7:0] LOW_WM_RESET = 8'h04;

    // FLUSH is write-only, so it always reads back as 0
    function automatic logic [31:0] pack_ctrl(input logic en, input logic [7:0] low_wm);
        logic [31:0] v;
        v                               = '0;
        v[CTRL_EN_BIT]                  = en;
        v[CTRL_WM_LSB +: 8]             = low_wm;
        return v;
    endfunction

    function automatic logic [31:0] pack_status(input logic [LEVEL_W-1:0] level,
                                                input logic empty,
                                                input logic full,
                                                input logic ovf);
        logic [31:0] v;
        v                 = '0;
        v[LEVEL_W-1:0]    = level;
        v[STAT_EMPTY_BIT] = empty;
        v[STAT_FULL_BIT]  = full;
        v[STAT_OVF_BIT]   = ovf;
        return v;
    endfunction

endpackage

// File: rtl/wb_sample_fifo_slave_core.sv
// Synchronous show-ahead FIFO with push/pop/flush and wrap-bit pointers.
module sample_fifo_core #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [WIDTH-1:0]           o_head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    // Same slot index but opposite wrap bits means the writer lapped the reader
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    // A full FIFO rejects the push even when a pop frees a slot in the same cycle
    assign w_push_ok = i_push & ~o_full & ~i_flush;
    assign w_pop_ok  = i_pop & ~o_empty & ~i_flush;

    // Storage array; no reset needed since contents are qualified by the pointers
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    // Pointer update; flush wins over any concurrent push or pop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/wb_sample_fifo_slave.sv
// Wishbone B3 classic slave feeding a sample FIFO that drains on a valid/ready stream.
module wb_sample_fifo_slave
    import wb_sample_fifo_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter logic [31:0] ID_VALUE = 32'hCA0D_0001
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic [31:0] smp_data,
    output logic        irq_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic               r_ack;
    logic               r_err;
    logic [31:0]        r_dat;
    logic               r_en;
    logic [7:0]         r_low_wm;
    logic               r_ovf;
    logic               r_irq;

    logic               w_req;
    logic [1:0]         w_reg;
    logic               w_bad;
    logic               w_acc;
    logic               w_wr;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_ctrl_wr;
    logic               w_ovf_clr;
    logic               w_full;
    logic               w_empty;
    logic [AW:0]        w_level;
    logic [LEVEL_W-1:0] w_level_ext;
    logic [31:0]        w_rdata;
    logic               w_unused;

    // Byte offset bits carry no information for word registers
    assign w_unused = ^wb_adr_i[1:0];

    // A new request is only taken while no termination is showing, giving one wait state
    assign w_req = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
    assign w_reg = wb_adr_i[3:2];

    assign w_bad = (wb_adr_i[31:4] != '0) ||
                   (wb_we_i && (w_reg == REG_TXDATA) && (wb_sel_i != 4'hF)) ||
                   (wb_we_i && (w_reg == REG_ID));

    assign w_acc     = w_req & ~w_bad;
    assign w_wr      = w_acc & wb_we_i;
    assign w_push    = w_wr & (w_reg == REG_TXDATA);
    assign w_ctrl_wr = w_wr & (w_reg == REG_CTRL);
    assign w_flush   = w_ctrl_wr & wb_sel_i[0] & wb_dat_i[CTRL_FLUSH_BIT];
    assign w_ovf_clr = w_wr & (w_reg == REG_STATUS) & wb_sel_i[2] & wb_dat_i[STAT_OVF_BIT];

    assign smp_valid = r_en & ~w_empty;
    assign w_pop     = smp_valid & smp_ready;

    assign w_level_ext = LEVEL_W'(w_level);

    sample_fifo_core #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_core (
        .i_clk       (clk_clk),
        .i_rst_n     (reset_reset_n),
        .i_push      (w_push),
        .i_push_data (wb_dat_i),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (w_level),
        .o_head      (smp_data)
    );

    // Read-data mux for the addressed register
    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_CTRL:   w_rdata = pack_ctrl(r_en, r_low_wm);
            REG_STATUS: w_rdata = pack_status(w_level_ext, w_empty, w_full, r_ovf);
            REG_ID:     w_rdata = ID_VALUE;
            default:    w_rdata = '0;
        endcase
    end

    // Bus termination and registered read data, valid for the single termination cycle
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_acc;
            r_err <= w_req & w_bad;
            r_dat <= (w_acc && !wb_we_i) ? w_rdata : '0;
        end
    end

    // CTRL register, byte lanes honoured individually
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_en     <= 1'b0;
            r_low_wm <= LOW_WM_RESET;
        end else if (w_ctrl_wr) begin
            if (wb_sel_i[0]) r_en     <= wb_dat_i[CTRL_EN_BIT];
            if (wb_sel_i[1]) r_low_wm <= wb_dat_i[CTRL_WM_LSB +: 8];
        end
    end

    // Sticky overflow flag: set on a dropped push, cleared by writing 1
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_full) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // Registered watermark/overflow interrupt
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_en & ((w_level_ext <= {1'b0, r_low_wm}) | r_ovf);
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_dat_o = r_dat;
    assign wb_rty_o = 1'b0;
    assign irq_o    = r_irq;

endmodule

// File: tb/tb_wb_sample_fifo_slave.sv
// Scoreboard bench: bus and stream expectations are queued at stimulus time and
// consumed by independent monitors whenever the DUT terminates a cycle or hands off a word.
module tb_wb_sample_fifo_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic [31:0] wb_adr = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic [31:0] wb_dat = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic        smp_valid;
    logic        smp_ready = 1'b0;
    logic [31:0] smp_data;
    logic        irq_o;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] dat;
        string       name;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [31:0] stream_q[$];

    wb_sample_fifo_slave #(
        .DEPTH    (16),
        .ID_VALUE (32'hCA0D_0001)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .wb_cyc_i      (wb_cyc),
        .wb_stb_i      (wb_stb),
        .wb_adr_i      (wb_adr),
        .wb_sel_i      (wb_sel),
        .wb_we_i       (wb_we),
        .wb_dat_i      (wb_dat),
        .wb_dat_o      (wb_dat_o),
        .wb_ack_o      (wb_ack_o),
        .wb_err_o      (wb_err_o),
        .wb_rty_o      (wb_rty_o),
        .smp_valid     (smp_valid),
        .smp_ready     (smp_ready),
        .smp_data      (smp_data),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Bus monitor: every termination consumes one expectation
    always @(negedge clk) begin : bus_mon
        bus_exp_t e;
        if (rst_n && (wb_ack_o || wb_err_o)) begin
            if (bus_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_term: ack=%b err=%b, expected no termination",
                         wb_ack_o, wb_err_o);
            end else begin
                e = bus_q.pop_front();
                check({e.name, "_term"}, {30'b0, wb_err_o, wb_ack_o}, {30'b0, e.err, ~e.err});
                if (e.chk) check({e.name, "_data"}, wb_dat_o, e.dat);
            end
        end
    end

    // Stream monitor: every valid&ready handshake consumes one expected word
    always @(negedge clk) begin
        if (rst_n && smp_valid && smp_ready) begin
            if (stream_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %h, expected no word", smp_data);
            end else begin
                check("stream_word", smp_data, stream_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the termination cycle
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input logic exp_err,
                           input logic [31:0] exp_dat, input string name,
                           input bit pop_with = 1'b0);
        bus_exp_t e;
        int       wait_cnt;
        e.err  = exp_err;
        e.chk  = !we && !exp_err;
        e.dat  = exp_dat;
        e.name = name;
        bus_q.push_back(e);
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we  = we;
        wb_adr = adr;
        wb_sel = sel;
        wb_dat = dat;
        if (pop_with) smp_ready = 1'b1;
        wait_cnt = 0;
        do begin
            @(posedge clk);
            #1;
            if (pop_with) smp_ready = 1'b0;
            wait_cnt++;
        end while (!(wb_ack_o || wb_err_o) && wait_cnt < 8);
        check({name, "_latency"}, wait_cnt, 1);
        if (!(wb_ack_o || wb_err_o)) void'(bus_q.pop_back());
        @(posedge clk);
        #1;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        check({name, "_one_cycle"}, {31'b0, wb_ack_o | wb_err_o}, 32'h0);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input string name);
        wb_xfer(1'b1, adr, 4'hF, dat, 1'b0, 32'h0, name);
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
        wb_xfer(1'b0, adr, 4'hF, 32'h0, 1'b0, exp, name);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (smp_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_valid_low"}, {31'b0, smp_valid}, 32'h0);
        check({name, "_all_words"}, stream_q.size(), 0);
    endtask

    initial begin
        // Reset values
        #1;
        check("rst_ack", {31'b0, wb_ack_o}, 0);
        check("rst_err", {31'b0, wb_err_o}, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_irq", {31'b0, irq_o}, 0);
        check("rst_valid", {31'b0, smp_valid}, 0);
        check("rst_rty", {31'b0, wb_rty_o}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        rd(32'hC, 32'hCA0D_0001, "id");
        rd(32'h0, 32'h0000_0400, "ctrl_rst");
        rd(32'h4, 32'h0000_0200, "status_rst");

        // Fill with EN=0, overflow, then drain
        for (int i = 0; i < 16; i++) begin
            wr(32'h8, 32'h1000 + i, $sformatf("fill%0d", i));
            stream_q.push_back(32'h1000 + i);
        end
        rd(32'h4, 32'h0000_0410, "status_full");
        wr(32'h8, 32'hDEAD_BEEF, "push_ovf");
        rd(32'h4, 32'h0001_0410, "status_ovf");
        check("irq_en0", {31'b0, irq_o}, 0);
        smp_ready = 1'b1;
        wr(32'h0, 32'h0000_0401, "ctrl_en");
        wait_drain("drain1");
        rd(32'h4, 32'h0001_0200, "status_drained");
        check("irq_low_level", {31'b0, irq_o}, 1);
        wr(32'h4, 32'h0001_0000, "ovf_clr0");
        rd(32'h4, 32'h0000_0200, "status_ovf_clr");

        // OVF-driven interrupt above the watermark
        smp_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr(32'h8, 32'h3000 + i, $sformatf("fillb%0d", i));
            stream_q.push_back(32'h3000 + i);
        end
        check("irq_above_wm", {31'b0, irq_o}, 0);
        wr(32'h8, 32'h3FFF, "push_ovf2");
        check("irq_ovf", {31'b0, irq_o}, 1);
        wr(32'h4, 32'h0001_0000, "ovf_clr1");
        check("irq_ovf_cleared", {31'b0, irq_o}, 0);
        rd(32'h4, 32'h0000_0410, "status_full2");
        smp_ready = 1'b1;
        wait_drain("drain2");
        smp_ready = 1'b0;

        // Steady level 5 with a pop on every push; wraps pointers several times
        for (int i = 0; i < 5; i++) begin
            wr(32'h8, 32'h4000 + i, $sformatf("pre%0d", i));
            stream_q.push_back(32'h4000 + i);
        end
        rd(32'h4, 32'h0000_0005, "level5");
        for (int i = 0; i < 48; i++) begin
            stream_q.push_back(32'h5000 + i);
            wb_xfer(1'b1, 32'h8, 4'hF, 32'h5000 + i, 1'b0, 32'h0,
                    $sformatf("pp%0d", i), 1'b1);
            rd(32'h4, 32'h0000_0005, $sformatf("lvl%0d", i));
        end
        smp_ready = 1'b1;
        wait_drain("drain3");
        smp_ready = 1'b0;

        // Byte lanes and error terminations
        wb_xfer(1'b1, 32'h0, 4'b0010, 32'h0000_0900, 1'b0, 32'h0, "ctrl_lane1");
        rd(32'h0, 32'h0000_0901, "ctrl_wm9");
        wb_xfer(1'b1, 32'h8, 4'b0011, 32'h0000_7777, 1'b1, 32'h0, "tx_partial");
        rd(32'h4, 32'h0000_0200, "status_no_push");
        wb_xfer(1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 32'h0, "bad_addr");
        wb_xfer(1'b1, 32'hC, 4'hF, 32'h0, 1'b1, 32'h0, "wr_id");
        rd(32'h0, 32'h0000_0901, "ctrl_unchanged");

        // Flush with 7 words held
        for (int i = 0; i < 7; i++) begin
            wr(32'h8, 32'h6000 + i, $sformatf("fl%0d", i));
        end
        rd(32'h4, 32'h0000_0007, "level7");
        wr(32'h0, 32'h0000_0903, "flush");
        check("flush_valid", {31'b0, smp_valid}, 0);
        rd(32'h4, 32'h0000_0200, "status_flushed");
        rd(32'h0, 32'h0000_0901, "ctrl_flush_reads0");

        // Reset in the middle of a transfer
        wr(32'h8, 32'h7000, "pre_rst");
        check("pre_rst_valid", {31'b0, smp_valid}, 1);
        check("pre_rst_irq", {31'b0, irq_o}, 1);
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we  = 1'b0;
        wb_adr = 32'hC;
        wb_sel = 4'hF;
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", {31'b0, wb_ack_o}, 0);
        check("mid_rst_dat", wb_dat_o, 0);
        check("mid_rst_irq", {31'b0, irq_o}, 0);
        check("mid_rst_valid", {31'b0, smp_valid}, 0);
        repeat (3) @(posedge clk);
        #1;
        check("held_rst_ack", {31'b0, wb_ack_o | wb_err_o}, 0);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(32'h0, 32'h0000_0400, "ctrl_after_rst");
        rd(32'h4, 32'h0000_0200, "status_after_rst");

        check("bus_q_empty", bus_q.size(), 0);
        check("stream_q_empty", stream_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
